// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle datapath controller.
//   - FSM state encoding
//   - instruction field codes (opcode, ext, ALU op, condition codes)
//   - PSR flag bit positions and result-mux selects
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_SHIFT,
        S_LOAD,
        S_STORE,
        S_JUMP,
        S_BRANCH,
        S_JAL,
        S_PC_INC
    } state_t;

    // opcode field [15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    // ext field [7:4] under OP_MEM
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // ALU operation codes (ext field of R-type)
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // condition codes (Rdst/cond field [11:8])
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_LO = 4'b1100;
    localparam logic [3:0] CC_UC = 4'b1110;

    // PSR flag bit positions
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // result mux selects
    localparam logic [1:0] CH_SHIFT = 2'b00;
    localparam logic [1:0] CH_ALU   = 2'b01;
    localparam logic [1:0] CH_IMM   = 2'b10;
    localparam logic [1:0] CH_LINK  = 2'b11;

    function automatic logic is_alu_op(input logic [3:0] ext);
        case (ext)
            ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND,
            ALU_OR, ALU_XOR, ALU_MOV: is_alu_op = 1'b1;
            default:                  is_alu_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch/jump condition check.
//   cond   - 4-bit condition code from the instruction
//   PSROut - datapath flags (C, L, F, Z, N)
//   taken  - condition holds for the given flags
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [7:0] PSROut,
    output logic       taken
);

    logic flag_c, flag_l, flag_z, flag_n;
    logic unused_psr;

    assign flag_c = PSROut[PSR_C];
    assign flag_l = PSROut[PSR_L];
    assign flag_z = PSROut[PSR_Z];
    assign flag_n = PSROut[PSR_N];

    // F and the reserved bits never take part in a condition
    assign unused_psr = ^{PSROut[PSR_F], PSROut[4:3], PSROut[1]};

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = flag_z;
            CC_NE:   taken = !flag_z;
            CC_CS:   taken = flag_c;
            CC_CC:   taken = !flag_c;
            CC_HI:   taken = flag_l;
            CC_LS:   taken = !flag_l;
            CC_LO:   taken = !flag_l && !flag_z;
            CC_GT:   taken = flag_n;
            CC_LE:   taken = !flag_n;
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// datapath_ctrl_fsm: multicycle control unit for the 16-bit datapath.
//   Inputs : clk, reset (async, active high), memdata (fetched instruction /
//            load data), mem_rdy (memory handshake), PSROut (datapath flags)
//   Outputs: mem_req/memWrite to memory; PC, PSR, register-file, ALU, shifter
//            and result-mux strobes to the datapath; illegal_op pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | request instruction, latch into ir on mem_rdy
// DECODE   | dispatch on op/ext, sample condition flags
// EXEC_R   | register-register ALU op, write result (not for CMP)
// EXEC_I   | ADDI (sign-extended) or MOVI (zero-extended immediate)
// SHIFT    | shift by sign-extended immediate, write result
// LOAD     | request read until mem_rdy, then one write-back cycle
// STORE    | request write until mem_rdy, then one completion cycle
// JUMP     | conditional jump, PC_INC when not taken
// BRANCH   | conditional PC-relative branch, PC_INC when not taken
// JAL      | write link register and jump
// PC_INC   | PC <= PC + 1
module datapath_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   memdata,
    input  logic               mem_rdy,
    input  logic [7:0]         PSROut,
    output logic               mem_req,
    output logic               memWrite,
    output logic               PCEN,
    output logic               PSREN,
    output logic               nextInstruction,
    output logic               updateAddress,
    output logic               StoreReg,
    output logic               WriteData,
    output logic               regWrite,
    output logic               ZeroExtend,
    output logic               PCinstruction,
    output logic               SrcB,
    output logic               shiftType,
    output logic               resultEn,
    output logic               jumpEN,
    output logic               BranchEN,
    output logic               jalEN,
    output logic [REGBITS-1:0] ALUcond,
    output logic [1:0]         chooseResult,
    output logic [WIDTH-1:0]   shiftDir,
    output logic [7:0]         shiftAmt,
    output logic               illegal_op
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic              taken_q, taken_d;
    // LOAD/STORE second phase: memory has answered
    logic              mem_done_q, mem_done_d;
    logic              cond_taken;

    logic [3:0] op, ext, imm;

    assign op  = ir_q[15:12];
    assign ext = ir_q[7:4];
    assign imm = ir_q[3:0];

    cond_eval u_cond_eval (
        .cond   (ir_q[11:8]),
        .PSROut (PSROut),
        .taken  (cond_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            taken_q    <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            taken_q    <= taken_d;
            mem_done_q <= mem_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        taken_d         = taken_q;
        mem_done_d      = 1'b0;
        mem_req         = 1'b0;
        memWrite        = 1'b0;
        PCEN            = 1'b0;
        PSREN           = 1'b0;
        nextInstruction = 1'b0;
        updateAddress   = 1'b0;
        StoreReg        = 1'b0;
        WriteData       = 1'b0;
        regWrite        = 1'b0;
        ZeroExtend      = 1'b0;
        PCinstruction   = 1'b0;
        SrcB            = 1'b0;
        shiftType       = 1'b0;
        resultEn        = 1'b0;
        jumpEN          = 1'b0;
        BranchEN        = 1'b0;
        jalEN           = 1'b0;
        ALUcond         = '0;
        chooseResult    = CH_SHIFT;
        shiftDir        = '0;
        shiftAmt        = '0;
        illegal_op      = 1'b0;

        // Outputs are held low for the whole reset assertion so an aborted
        // instruction cannot leave a partial write behind.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req       = 1'b1;
                    updateAddress = 1'b1;
                    if (mem_rdy) begin
                        nextInstruction = 1'b1;
                        ir_d            = memdata;
                        state_d         = S_DECODE;
                    end
                end
                S_DECODE: begin
                    taken_d = cond_taken;
                    state_d = S_PC_INC;
                    case (op)
                        OP_RTYPE: if (is_alu_op(ext)) state_d = S_EXEC_R;
                        OP_ADDI,
                        OP_MOVI:  state_d = S_EXEC_I;
                        OP_SHIFT: state_d = S_SHIFT;
                        OP_BCOND: state_d = S_BRANCH;
                        OP_MEM: begin
                            case (ext)
                                EXT_LOAD:  state_d = S_LOAD;
                                EXT_STOR:  state_d = S_STORE;
                                EXT_JAL:   state_d = S_JAL;
                                EXT_JCOND: state_d = S_JUMP;
                                default:   state_d = S_PC_INC;
                            endcase
                        end
                        default:  state_d = S_PC_INC;
                    endcase
                    // only undecodable instructions fall straight to PC_INC
                    illegal_op = (state_d == S_PC_INC);
                end
                S_EXEC_R: begin
                    ALUcond      = REGBITS'(ext);
                    SrcB         = 1'b1;
                    chooseResult = CH_ALU;
                    resultEn     = 1'b1;
                    PSREN        = 1'b1;
                    WriteData    = 1'b1;
                    regWrite     = (ext != ALU_CMP);
                    state_d      = S_PC_INC;
                end
                S_EXEC_I: begin
                    resultEn  = 1'b1;
                    WriteData = 1'b1;
                    regWrite  = 1'b1;
                    if (op == OP_MOVI) begin
                        ALUcond      = REGBITS'(ext);
                        chooseResult = CH_IMM;
                        ZeroExtend   = 1'b1;
                    end else begin
                        ALUcond      = REGBITS'(ALU_ADD);
                        chooseResult = CH_ALU;
                        PSREN        = 1'b1;
                    end
                    state_d = S_PC_INC;
                end
                S_SHIFT: begin
                    shiftType    = ext[0];
                    shiftAmt     = {{4{imm[3]}}, imm};
                    // a negative amount means shift right
                    shiftDir     = {WIDTH{imm[3]}};
                    chooseResult = CH_SHIFT;
                    regWrite     = 1'b1;
                    WriteData    = 1'b1;
                    resultEn     = 1'b1;
                    state_d      = S_PC_INC;
                end
                S_LOAD: begin
                    StoreReg = 1'b1;
                    if (!mem_done_q) begin
                        mem_req    = 1'b1;
                        mem_done_d = mem_rdy;
                    end else begin
                        regWrite = 1'b1;
                        state_d  = S_PC_INC;
                    end
                end
                S_STORE: begin
                    if (!mem_done_q) begin
                        mem_req    = 1'b1;
                        memWrite   = 1'b1;
                        StoreReg   = 1'b1;
                        mem_done_d = mem_rdy;
                    end else begin
                        state_d = S_PC_INC;
                    end
                end
                S_JUMP: begin
                    if (taken_q) begin
                        PCEN    = 1'b1;
                        jumpEN  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_PC_INC;
                    end
                end
                S_BRANCH: begin
                    if (taken_q) begin
                        PCEN     = 1'b1;
                        BranchEN = 1'b1;
                        resultEn = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_PC_INC;
                    end
                end
                S_JAL: begin
                    jalEN        = 1'b1;
                    chooseResult = CH_LINK;
                    regWrite     = 1'b1;
                    PCEN         = 1'b1;
                    resultEn     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_PC_INC: begin
                    PCEN          = 1'b1;
                    PCinstruction = 1'b1;
                    resultEn      = 1'b1;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
module tb_datapath_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memdata;
    logic        mem_rdy;
    logic [7:0]  PSROut;
    logic        mem_req, memWrite, PCEN, PSREN, nextInstruction, updateAddress;
    logic        StoreReg, WriteData, regWrite, ZeroExtend, PCinstruction, SrcB;
    logic        shiftType, resultEn, jumpEN, BranchEN, jalEN, illegal_op;
    logic [3:0]  ALUcond;
    logic [1:0]  chooseResult;
    logic [15:0] shiftDir;
    logic [7:0]  shiftAmt;

    always #5 clk = ~clk;

    datapath_ctrl_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk(clk), .reset(reset), .memdata(memdata), .mem_rdy(mem_rdy), .PSROut(PSROut),
        .mem_req(mem_req), .memWrite(memWrite), .PCEN(PCEN), .PSREN(PSREN),
        .nextInstruction(nextInstruction), .updateAddress(updateAddress),
        .StoreReg(StoreReg), .WriteData(WriteData), .regWrite(regWrite),
        .ZeroExtend(ZeroExtend), .PCinstruction(PCinstruction), .SrcB(SrcB),
        .shiftType(shiftType), .resultEn(resultEn), .jumpEN(jumpEN),
        .BranchEN(BranchEN), .jalEN(jalEN), .ALUcond(ALUcond),
        .chooseResult(chooseResult), .shiftDir(shiftDir), .shiftAmt(shiftAmt),
        .illegal_op(illegal_op)
    );

    // One instruction as seen from outside: cycle count after the fetch
    // handshake, number of cycles each strobe was high, and the operand
    // selects seen in the first result-producing cycle.
    typedef struct {
        logic [15:0] ins;
        int exec_cyc, n_rw, n_psren, n_br, n_jmp, n_jal, n_ill, n_memreq, n_memwr, n_pcen;
        bit cap;
        int alucond, choose, srcb, zext, wdata, sreg, stype, sdir, samt;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;

    logic [3:0] alu_ops [7]  = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    logic [3:0] bad_ops [10] = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};

    task automatic chk(input string nm, input logic [15:0] ins, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s instr=%h got=%0d expected=%0d", nm, ins, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic bit cond_true(input logic [3:0] cd, input logic [7:0] psr);
        bit c, l, z, n;
        c = psr[0]; l = psr[2]; z = psr[6]; n = psr[7];
        case (cd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'hC: return !l && !z;
            4'h6: return n;
            4'h7: return !n;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: per-instruction outcome from the instruction-set rules.
    // exec_cyc counts DECODE onward up to the next FETCH.
    function automatic txn_t model(input logic [15:0] ins, input logic [7:0] psr, input int mw);
        txn_t t;
        logic [3:0] op, cd, ext, lo;
        bit tk;
        t = '{default: 0};
        t.ins = ins;
        op = ins[15:12]; cd = ins[11:8]; ext = ins[7:4]; lo = ins[3:0];
        tk = cond_true(cd, psr);
        t.exec_cyc = 3;
        t.n_pcen   = 1;
        case (op)
            4'h0: begin
                t.n_psren = 1; t.n_rw = (ext != 4'hB) ? 1 : 0;
                t.alucond = ext; t.choose = 1; t.srcb = 1; t.wdata = 1;
            end
            4'h5: begin
                t.n_psren = 1; t.n_rw = 1; t.alucond = 5; t.choose = 1; t.wdata = 1;
            end
            4'hD: begin
                t.n_rw = 1; t.alucond = ext; t.choose = 2; t.zext = 1; t.wdata = 1;
            end
            4'h8: begin
                t.n_rw = 1; t.choose = 0; t.wdata = 1; t.stype = ext[0];
                t.samt = lo[3] ? (240 + lo) : lo;
                t.sdir = lo[3] ? 16'hFFFF : 0;
            end
            4'hC: if (tk) begin t.exec_cyc = 2; t.n_br = 1; end
            4'h4: begin
                case (ext)
                    4'h0: begin t.exec_cyc = mw + 4; t.n_memreq = mw + 1; t.n_rw = 1; t.sreg = 1; end
                    4'h4: begin t.exec_cyc = mw + 4; t.n_memreq = mw + 1; t.n_memwr = mw + 1; end
                    4'h8: begin t.exec_cyc = 2; t.n_rw = 1; t.n_jal = 1; t.choose = 3; end
                    default: if (tk) begin t.exec_cyc = 2; t.n_jmp = 1; end
                endcase
            end
            default: begin t.exec_cyc = 2; t.n_ill = 1; end
        endcase
        return t;
    endfunction

    task automatic wait_fetch();
        int n = 0;
        while (updateAddress !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        if (updateAddress !== 1'b1) timeout("wait_fetch");
    endtask

    task automatic issue(input logic [15:0] ins, input logic [7:0] psr, input int fw, input int mw);
        int n;
        sb.push_back(model(ins, psr, mw));
        wait_fetch();
        memdata = ins; PSROut = psr; mem_rdy = 1'b0;
        repeat (fw) @(negedge clk);
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        memdata = 16'($urandom);
        if (ins[15:12] == 4'h4 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4)) begin
            n = 0;
            while (!(mem_req === 1'b1 && updateAddress === 1'b0) && n < 64) begin @(negedge clk); n++; end
            if (n >= 64) timeout("wait_mem_req");
            repeat (mw) @(negedge clk);
            mem_rdy = 1'b1;
            @(negedge clk);
            mem_rdy = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) timeout("scoreboard_drain");
    endtask

    function automatic int outs_ones();
        return $countones({mem_req, memWrite, PCEN, PSREN, nextInstruction, updateAddress,
                           StoreReg, WriteData, regWrite, ZeroExtend, PCinstruction, SrcB,
                           shiftType, resultEn, jumpEN, BranchEN, jalEN, illegal_op,
                           ALUcond, chooseResult, shiftDir, shiftAmt});
    endfunction

    // Monitor: builds a transaction from each fetch handshake until the next
    // FETCH cycle, then compares it with the oldest expected entry.
    initial begin : monitor
        txn_t cur, e;
        bit   open;
        open = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || reset) begin
                open = 1'b0;
            end else begin
                if (open && updateAddress) begin
                    open = 1'b0;
                    if (sb.size() == 0) begin
                        timeout("scoreboard_empty");
                    end else begin
                        e = sb.pop_front();
                        chk("exec_cycles", e.ins, cur.exec_cyc, e.exec_cyc);
                        chk("regWrite_cnt", e.ins, cur.n_rw, e.n_rw);
                        chk("PSREN_cnt", e.ins, cur.n_psren, e.n_psren);
                        chk("BranchEN_cnt", e.ins, cur.n_br, e.n_br);
                        chk("jumpEN_cnt", e.ins, cur.n_jmp, e.n_jmp);
                        chk("jalEN_cnt", e.ins, cur.n_jal, e.n_jal);
                        chk("illegal_cnt", e.ins, cur.n_ill, e.n_ill);
                        chk("mem_req_cnt", e.ins, cur.n_memreq, e.n_memreq);
                        chk("memWrite_cnt", e.ins, cur.n_memwr, e.n_memwr);
                        chk("PCEN_cnt", e.ins, cur.n_pcen, e.n_pcen);
                        chk("ALUcond", e.ins, cur.alucond, e.alucond);
                        chk("chooseResult", e.ins, cur.choose, e.choose);
                        chk("SrcB", e.ins, cur.srcb, e.srcb);
                        chk("ZeroExtend", e.ins, cur.zext, e.zext);
                        chk("WriteData", e.ins, cur.wdata, e.wdata);
                        chk("StoreReg", e.ins, cur.sreg, e.sreg);
                        chk("shiftType", e.ins, cur.stype, e.stype);
                        chk("shiftDir", e.ins, cur.sdir, e.sdir);
                        chk("shiftAmt", e.ins, cur.samt, e.samt);
                    end
                end
                if (nextInstruction) begin
                    open = 1'b1;
                    cur  = '{default: 0};
                end else if (open) begin
                    cur.exec_cyc++;
                    cur.n_rw     += int'(regWrite);
                    cur.n_psren  += int'(PSREN);
                    cur.n_br     += int'(BranchEN);
                    cur.n_jmp    += int'(jumpEN);
                    cur.n_jal    += int'(jalEN);
                    cur.n_ill    += int'(illegal_op);
                    cur.n_memreq += int'(mem_req);
                    cur.n_memwr  += int'(memWrite);
                    cur.n_pcen   += int'(PCEN);
                    if (!cur.cap && ((resultEn && !PCinstruction) || regWrite)) begin
                        cur.cap     = 1'b1;
                        cur.alucond = int'(ALUcond);
                        cur.choose  = int'(chooseResult);
                        cur.srcb    = int'(SrcB);
                        cur.zext    = int'(ZeroExtend);
                        cur.wdata   = int'(WriteData);
                        cur.sreg    = int'(StoreReg);
                        cur.stype   = int'(shiftType);
                        cur.sdir    = int'(shiftDir);
                        cur.samt    = int'(shiftAmt);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] ins;
        reset = 1'b1; mem_rdy = 1'b0; memdata = 16'h0000; PSROut = 8'h00;
        repeat (3) @(negedge clk);
        mem_rdy = 1'b1;
        #1;
        chk("reset_outputs_zero", 16'h0000, outs_ones(), 0);
        @(negedge clk);
        mem_rdy = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("fetch_after_reset", 16'h0000, int'(updateAddress && mem_req), 1);

        // directed cases
        issue(16'h0152, 8'h00, 0, 0);
        issue(16'hC0F2, 8'h40, 0, 0);
        issue(16'hC0F2, 8'h00, 1, 0);
        issue(16'h4000, 8'h00, 0, 3);
        issue(16'h4040, 8'h00, 2, 1);
        issue(16'h4884, 8'h00, 0, 0);
        issue(16'hF000, 8'h00, 0, 0);
        issue(16'h840F, 8'h00, 0, 0);
        issue(16'h8713, 8'h00, 0, 0);
        issue(16'h03B4, 8'h00, 0, 0);
        issue(16'hD2A7, 8'h00, 0, 0);
        issue(16'h4CC0, 8'h04, 0, 0);
        issue(16'h45C0, 8'h04, 0, 0);
        issue(16'hCC05, 8'h00, 0, 0);
        issue(16'hCC05, 8'h40, 0, 0);

        // randomized instruction mix
        for (int i = 0; i < 150; i++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 9))
                0: begin ins[15:12] = 4'h0; ins[7:4] = alu_ops[$urandom_range(0, 6)]; end
                1: ins[15:12] = 4'h5;
                2: ins[15:12] = 4'hD;
                3: ins[15:12] = 4'h8;
                4: begin ins[15:12] = 4'h4; ins[7:4] = 4'h0; end
                5: begin ins[15:12] = 4'h4; ins[7:4] = 4'h4; end
                6: begin ins[15:12] = 4'h4; ins[7:4] = 4'h8; end
                7: begin ins[15:12] = 4'h4; ins[7:4] = 4'hC; end
                8: ins[15:12] = 4'hC;
                default: ins[15:12] = bad_ops[$urandom_range(0, 9)];
            endcase
            issue(ins, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        drain();

        // reset in the middle of an R-type execute
        mon_en = 1'b0;
        wait_fetch();
        memdata = 16'h0152; PSROut = 8'h00; mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        @(negedge clk);
        chk("exec_r_regWrite", 16'h0152, int'(regWrite), 1);
        chk("exec_r_ALUcond", 16'h0152, int'(ALUcond), 5);
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs_zero", 16'h0152, outs_ones(), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("fetch_after_abort", 16'h0152, int'(updateAddress && mem_req), 1);
        @(negedge clk);
        chk("no_writeback_after_abort", 16'h0152, int'(regWrite || PCEN), 0);
        mon_en = 1'b1;
        issue(16'h0152, 8'h00, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
- Multicycle control unit that sequences the 16-bit datapath: fetch, decode, execute, writeback and PC update.
- Drives every datapath control strobe as a Moore decode of the current state and a latched copy of the instruction.
- Handshakes with instruction/data memory through a ready signal.
- Sits between the memory interface and the datapath in the top-level CPU.

Parameters:
- WIDTH, 16, instruction/data width.
- REGBITS, 4, register-index width (ALU op width equals REGBITS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memdata  in  WIDTH  memory read data; instruction during fetch.
- mem_rdy  in  1  memory has valid read data / accepted write this cycle.
- PSROut  in  8  datapath flags: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N.
- mem_req  out  1  memory access request.
- memWrite  out  1  store strobe.
- PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, resultEn, jumpEN, BranchEN, jalEN  out  1 each  datapath strobes.
- ALUcond  out  REGBITS  ALU operation select.
- chooseResult  out  2  result mux: 00 shifter, 01 ALU, 10 immediate, 11 PC link.
- shiftDir  out  WIDTH  shift direction/amount operand; all ones = right.
- shiftAmt  out  8  shift immediate.
- illegal_op  out  1  one-cycle pulse on undecodable opcode.

Behaviour:
- Instruction format: [15:12] op, [11:8] Rdst/cond, [7:4] ext, [3:0] Rsrc/imm.
  - op 0000 R-type; ext is the ALU op (0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV).
  - op 0101 ADDI, 1101 MOVI, 1000 shift, 0100 mem/jump (ext 0000 LOAD, 0100 STOR, 1000 JAL, 1100 Jcond), 1100 Bcond.
  - Any other op is illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, SHIFT, LOAD, STORE, JUMP, BRANCH, JAL, PC_INC.
- Reset: state=FETCH, internal ir=0, every output 0. Asserting reset mid-instruction aborts it with no partial write. Fetch restarts on the first edge after deassert.
- FETCH:
  - mem_req=1, updateAddress=1.
  - Holds while mem_rdy=0.
  - On mem_rdy=1: nextInstruction=1, ir<=memdata, go to DECODE.
- DECODE: all strobes 0; 1-cycle dispatch on op/ext.
- EXEC_R:
  - ALUcond=ext, SrcB=1, chooseResult=01, resultEn=1, PSREN=1.
  - regWrite=1, WriteData=1, except CMP (regWrite=0).
  - Next state PC_INC.
- EXEC_I:
  - Same as EXEC_R but SrcB=0.
  - ADDI: ALUcond=0101, sign-extend.
  - MOVI: chooseResult=10, ZeroExtend=1, PSREN=0.
  - Next state PC_INC.
- SHIFT:
  - shiftType=ext[0]; shiftAmt=sign-extended ir[3:0]; shiftDir=FFFF if imm negative else 0000.
  - chooseResult=00, regWrite=1, WriteData=1, resultEn=1.
  - Next state PC_INC.
- LOAD:
  - mem_req=1, StoreReg=1, WriteData=0.
  - Waits for mem_rdy, then regWrite=1 for exactly one cycle.
  - Next state PC_INC.
- STORE:
  - mem_req=1, memWrite=1, StoreReg=1, held until mem_rdy.
  - Next state PC_INC.
- Condition evaluation on PSROut, using the cond field:
  - 0000 EQ (Z)
  - 0001 NE (!Z)
  - 0010 CS (C)
  - 0011 CC (!C)
  - 0100 HI (L)
  - 0101 LS (!L)
  - 1100 LO (!L&!Z)
  - 0110 GT (N)
  - 0111 LE (!N)
  - 1110 UC (always)
  - any other code: never taken
- Branches and jumps:
  - BRANCH (taken): PCEN=1, BranchEN=1, SrcB=0, resultEn=1; next state FETCH.
  - JUMP (taken): PCEN=1, jumpEN=1; next state FETCH.
  - Not-taken branch or jump goes to PC_INC instead.
- JAL: jalEN=1, chooseResult=11, regWrite=1, PCEN=1, resultEn=1; next state FETCH.
- PC_INC: PCEN=1, PCinstruction=1, resultEn=1; next state FETCH.
- Illegal op: DECODE pulses illegal_op and goes to PC_INC (treated as NOP).
- Strobes are single-cycle per state. Flags are sampled in DECODE; a PSR write in the same cycle is not visible.
- Latency with mem_rdy tied high:
  - ALU, immediate and shift: 4 cycles.
  - Load and store: 5 cycles.
  - Taken branch, jump or JAL: 3 cycles.
  - Not-taken branch or jump: 4 cycles.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode and ext localparams;
  - ALU op codes;
  - condition-code constants;
  - PSR bit indices.
- One sub-module, cond_eval: combinational condition check from (cond, PSROut) to taken.

Test Plan:
- ADD: reset, mem_rdy=1, memdata=0152 → DECODE→EXEC_R shows ALUcond=0101, regWrite=1, PSREN=1, chooseResult=01; PC_INC has PCEN=1, PCinstruction=1; FETCH again on cycle 5.
- BEQ taken: memdata=C0F2 with PSROut=40 → BRANCH with PCEN=1, BranchEN=1, then FETCH. Same instruction with PSROut=00 → PC_INC, BranchEN never 1.
- LOAD with mem_rdy low for 3 cycles: memdata=4000 → stays in LOAD with mem_req=1 for 3 cycles; regWrite=1 for exactly one cycle after mem_rdy.
- JAL: memdata=4884 → one cycle with jalEN=1, chooseResult=11, regWrite=1, PCEN=1; next state FETCH.
- Illegal op: memdata=F000 → illegal_op high one cycle, no regWrite, PC_INC follows. Reset asserted in EXEC_R → all outputs 0 immediately, FETCH after release.
- Shift right: memdata=840F → SHIFT with shiftDir=FFFF, shiftAmt=FF, chooseResult=00, regWrite=1.
